cprs_row_final_add: RTL and testbench

//  Downstream stage of a row of approximate 4:2 compressors. Takes one row of W

---
 rtl/cprs_pkg.sv | 27 ++
 rtl/cprs_row_final_add_if.sv | 40 ++++
 rtl/cprs_popcount.sv | 26 ++
 rtl/cprs_row_final_add.sv | 158 +++++++++++++++
 tb/tb_cprs_row_final_add.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/cprs_pkg.sv
// ---------------------------------------------------------------------------
// cprs_pkg
// Shared width helpers for the compressor-row final adder slice.
//   RES_W(w)    : width of a resolved row value (w + 3 bits, no overflow)
//   ERRB_W(w)   : width of a per-beat error popcount ($clog2(w + 1))
//   CNT_MAX(n)  : largest value an n-bit saturating counter may hold
// The stage-1 payload struct depends on the row width, so the top module
// declares it locally from these helpers.
// ---------------------------------------------------------------------------
package cprs_pkg;

    // A row of w columns with sum, carry<<1 and err<<2 never exceeds w+3 bits.
    function automatic int RES_W(input int w);
        return w + 3;
    endfunction

    // Enough bits to count every column of the row as erroring.
    function automatic int ERRB_W(input int w);
        return $clog2(w + 1);
    endfunction

    // All-ones value of an n-bit counter; callers cast it down to n bits.
    function automatic longint unsigned CNT_MAX(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

endpackage

// File: rtl/cprs_row_final_add_if.sv
// ---------------------------------------------------------------------------
// cprs_row_final_add_if
// Bundles the row-beat input handshake and the result output handshake.
//   in_valid/in_ready            : row beat handshake
//   sum_vec/carry_vec/err_vec    : compressor outputs, W bits each
//   out_valid/out_ready          : result handshake
//   result                       : resolved row value, RES_W(W) bits
//   err_bits                     : popcount of err_vec for the beat
//   err_cnt                      : saturating count of erroring beats
// Modports: master = producer/consumer side, slave = the adder stage.
// ---------------------------------------------------------------------------
interface cprs_row_final_add_if
    import cprs_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
);

    logic                    in_valid;
    logic                    in_ready;
    logic [W-1:0]            sum_vec;
    logic [W-1:0]            carry_vec;
    logic [W-1:0]            err_vec;
    logic                    out_valid;
    logic                    out_ready;
    logic [RES_W(W)-1:0]     result;
    logic [ERRB_W(W)-1:0]    err_bits;
    logic [CNT_W-1:0]        err_cnt;

    modport master (
        output in_valid, sum_vec, carry_vec, err_vec, out_ready,
        input  in_ready, out_valid, result, err_bits, err_cnt
    );

    modport slave (
        input  in_valid, sum_vec, carry_vec, err_vec, out_ready,
        output in_ready, out_valid, result, err_bits, err_cnt
    );

endinterface

// File: rtl/cprs_popcount.sv
// ---------------------------------------------------------------------------
// cprs_popcount
// Combinational population count of a W-bit vector.
//   vec_i   : input vector
//   count_o : number of set bits, ERRB_W(W) wide
// ---------------------------------------------------------------------------
module cprs_popcount
    import cprs_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]         vec_i,
    output logic [ERRB_W(W)-1:0] count_o
);

    localparam int CW = ERRB_W(W);

    // Plain ripple of one-bit additions; synthesis rebalances it into a tree.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < W; i++) begin
            count_o = count_o + CW'(vec_i[i]);
        end
    end

endmodule

// File: rtl/cprs_row_final_add.sv
// ---------------------------------------------------------------------------
// cprs_row_final_add
// Resolves one row of approximate 4:2 compressor outputs per beat into a
// binary value with a two-stage pipelined carry-propagate adder, and counts
// beats that carried any approximation error.
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : cprs_row_final_add_if.slave (handshakes, row vectors, results)
// Parameters: W columns, CNT_W error-counter width, SPLIT adder cut point.
// Build option: CPRS_ERR_COMP_EN adds err_vec<<2 back in, giving the exact
// column sum; without it the result is the raw approximate sum + carry<<1.
// ---------------------------------------------------------------------------
module cprs_row_final_add
    import cprs_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16,
    parameter int SPLIT = W / 2
) (
    input logic                   clk,
    input logic                   rst,
    cprs_row_final_add_if.slave   bus
);

    localparam int RW = RES_W(W);
    localparam int EW = ERRB_W(W);
    localparam int HW = RW - SPLIT;
    localparam logic [CNT_W-1:0] CntMax = CNT_W'(CNT_MAX(CNT_W));

    typedef struct packed {
        logic [SPLIT-1:0] lo_sum;
        logic             carry;
        logic [HW-1:0]    hi_a;
        logic [HW-1:0]    hi_b;
        logic [EW-1:0]    err_bits;
    } s1_t;

    logic [RW-1:0]    opA;
    logic [RW-1:0]    opB;
    logic [SPLIT:0]   loAdd;
    logic [EW-1:0]    errCount;
    logic [HW-1:0]    hiSum;
    s1_t              s1Payload;

    logic             s1Valid_q, s1Valid_d;
    s1_t              s1_q, s1_d;
    logic             s2Valid_q, s2Valid_d;
    logic [RW-1:0]    result_q, result_d;
    logic [EW-1:0]    errBits_q, errBits_d;
    logic [CNT_W-1:0] errCnt_q, errCnt_d;

    logic             s2Adv;
    logic             inReady;
    logic             inFire;

`ifdef CPRS_ERR_COMP_EN
    logic [RW-1:0]    rawA;
    logic [RW-1:0]    rawB;
    logic [RW-1:0]    rawC;

    // Three operands are folded to two with a carry-save layer so the
    // pipelined adder below stays a plain two-input adder. The top majority
    // bit is always zero because the total fits in RW bits.
    assign rawA = RW'(bus.sum_vec);
    assign rawB = RW'(bus.carry_vec) << 1;
    assign rawC = RW'(bus.err_vec) << 2;
    assign opA  = rawA ^ rawB ^ rawC;
    assign opB  = ((rawA & rawB) | (rawA & rawC) | (rawB & rawC)) << 1;
`else
    // Raw approximate value: sum bits plus carry bits one column up.
    assign opA = RW'(bus.sum_vec);
    assign opB = RW'(bus.carry_vec) << 1;
`endif

    cprs_popcount #(.W(W)) uPopcount (
        .vec_i   (bus.err_vec),
        .count_o (errCount)
    );

    // Low half of the adder resolves in stage 1; its carry-out and the raw
    // upper slices travel to stage 2 together with the popcount.
    assign loAdd = {1'b0, opA[SPLIT-1:0]} + {1'b0, opB[SPLIT-1:0]};

    always_comb begin
        s1Payload          = '0;
        s1Payload.lo_sum   = loAdd[SPLIT-1:0];
        s1Payload.carry    = loAdd[SPLIT];
        s1Payload.hi_a     = opA[RW-1:SPLIT];
        s1Payload.hi_b     = opB[RW-1:SPLIT];
        s1Payload.err_bits = errCount;
    end

    // Upper half finishes in stage 2 using the registered carry.
    assign hiSum = s1_q.hi_a + s1_q.hi_b + HW'(s1_q.carry);

    // Ready ripples backwards combinationally so a full pipeline still takes
    // a new beat in the same cycle the consumer drains one.
    assign s2Adv   = !s2Valid_q | bus.out_ready;
    assign inReady = !s1Valid_q | s2Adv;
    assign inFire  = bus.in_valid & inReady;

    // Next-state for both pipeline stages and the saturating error counter.
    // Stage 2 only changes when it may advance, which keeps a presented
    // result stable until the consumer takes it.
    always_comb begin
        s1Valid_d = s1Valid_q;
        s1_d      = s1_q;
        s2Valid_d = s2Valid_q;
        result_d  = result_q;
        errBits_d = errBits_q;
        errCnt_d  = errCnt_q;

        if (inReady) begin
            s1Valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_d = s1Payload;
            end
        end

        if (s2Adv) begin
            s2Valid_d = s1Valid_q;
            if (s1Valid_q) begin
                result_d  = {hiSum, s1_q.lo_sum};
                errBits_d = s1_q.err_bits;
            end
        end

        if (inFire && (|bus.err_vec) && (errCnt_q != CntMax)) begin
            errCnt_d = errCnt_q + CNT_W'(1);
        end
    end

    // State registers; reset discards any beats still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1_q      <= '0;
            s2Valid_q <= 1'b0;
            result_q  <= '0;
            errBits_q <= '0;
            errCnt_q  <= '0;
        end else begin
            s1Valid_q <= s1Valid_d;
            s1_q      <= s1_d;
            s2Valid_q <= s2Valid_d;
            result_q  <= result_d;
            errBits_q <= errBits_d;
            errCnt_q  <= errCnt_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = s2Valid_q;
    assign bus.result    = result_q;
    assign bus.err_bits  = errBits_q;
    assign bus.err_cnt   = errCnt_q;

endmodule

// File: tb/tb_cprs_row_final_add.sv
// ---------------------------------------------------------------------------
// tb_cprs_row_final_add
// Directed bench for cprs_row_final_add at W=8. A second instance with a
// 4-bit error counter sees the same stimulus so counter saturation can be
// observed without thousands of beats. Honours CPRS_ERR_COMP_EN.
// ---------------------------------------------------------------------------
module tb_cprs_row_final_add;

`ifdef CPRS_ERR_COMP_EN
    localparam bit CompEn = 1'b1;
`else
    localparam bit CompEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   errors;
    int   checks;
    int   cntModel;

    cprs_row_final_add_if #(.W(8), .CNT_W(16)) bus ();
    cprs_row_final_add_if #(.W(8), .CNT_W(4))  satBus ();

    cprs_row_final_add #(.W(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cprs_row_final_add #(.W(8), .CNT_W(4)) dutSat (
        .clk (clk),
        .rst (rst),
        .bus (satBus)
    );

    // The saturating instance mirrors every input of the main instance.
    assign satBus.in_valid  = bus.in_valid;
    assign satBus.sum_vec   = bus.sum_vec;
    assign satBus.carry_vec = bus.carry_vec;
    assign satBus.err_vec   = bus.err_vec;
    assign satBus.out_ready = bus.out_ready;

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  sum;
        logic [7:0]  carry;
        logic [7:0]  err;
        logic [10:0] expRaw;
        logic [10:0] expComp;
        logic [3:0]  expErrBits;
    } vec_t;

    vec_t vecs [8];

    logic [10:0] expResQ [$];
    logic [3:0]  expEbQ  [$];

    // Reference value of a row: sum + carry<<1, plus err<<2 when compensated.
    function automatic logic [10:0] modelResult(input logic [7:0] s,
                                                input logic [7:0] c,
                                                input logic [7:0] e);
        logic [10:0] r;
        r = 11'(s) + (11'(c) << 1);
        if (CompEn) begin
            r = r + (11'(e) << 2);
        end
        return r;
    endfunction

    // Drives one set of row inputs; called just after a falling edge.
    task automatic applyStimulus(input logic v, input logic [7:0] s,
                                 input logic [7:0] c, input logic [7:0] e);
        bus.in_valid  = v;
        bus.sum_vec   = s;
        bus.carry_vec = c;
        bus.err_vec   = e;
    endtask

    // One comparison; prints a FAIL line on disagreement.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    initial begin
        int          got;
        logic [7:0]  rs, rc, re;
        logic [10:0] xRes, yRes;
        logic [3:0]  xEb;

        errors   = 0;
        checks   = 0;
        cntModel = 0;

        vecs[0] = '{8'h0F, 8'h01, 8'h00, 11'h011, 11'h011, 4'd0};
        vecs[1] = '{8'h00, 8'h00, 8'h01, 11'h000, 11'h004, 4'd1};
        vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 11'h2FD, 11'h6F9, 4'd8};
        vecs[3] = '{8'hAA, 8'h55, 8'h0F, 11'h154, 11'h190, 4'd4};
        vecs[4] = '{8'h80, 8'h80, 8'h80, 11'h180, 11'h380, 4'd1};
        vecs[5] = '{8'h00, 8'h00, 8'h00, 11'h000, 11'h000, 4'd0};
        vecs[6] = '{8'h12, 8'h34, 8'h20, 11'h07A, 11'h0FA, 4'd1};
        vecs[7] = '{8'hF0, 8'h0F, 8'h00, 11'h10E, 11'h10E, 4'd0};

        // Reset state and first-cycle readiness.
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset result",    32'(bus.result),    32'd0);
        checkOutput("reset err_bits",  32'(bus.err_bits),  32'd0);
        checkOutput("reset err_cnt",   32'(bus.err_cnt),   32'd0);
        checkOutput("reset in_ready",  32'(bus.in_ready),  32'd1);

        // Single isolated beats from the table, checking the two-cycle latency.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, vecs[i].sum, vecs[i].carry, vecs[i].err);
            checkOutput("vec in_ready", 32'(bus.in_ready), 32'd1);
            if (vecs[i].err != 8'h00) cntModel++;
            @(negedge clk);
            applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
            checkOutput("vec early out_valid", 32'(bus.out_valid), 32'd0);
            @(negedge clk);
            checkOutput("vec out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("vec result", 32'(bus.result),
                        32'(CompEn ? vecs[i].expComp : vecs[i].expRaw));
            checkOutput("vec err_bits", 32'(bus.err_bits), 32'(vecs[i].expErrBits));
            checkOutput("vec err_cnt",  32'(bus.err_cnt),  32'(cntModel));
            @(negedge clk);
        end

        // Back-to-back random beats; exactly 16 results in 18 cycles means no bubbles.
        got = 0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            if (bus.out_valid) begin
                if (expResQ.size() > 0) begin
                    checkOutput("burst result",   32'(bus.result),   32'(expResQ[0]));
                    checkOutput("burst err_bits", 32'(bus.err_bits), 32'(expEbQ[0]));
                    void'(expResQ.pop_front());
                    void'(expEbQ.pop_front());
                    got++;
                end else begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL burst extra: out_valid=1, expected no pending result");
                end
            end
            if (cyc < 16) begin
                rs = 8'($urandom);
                rc = 8'($urandom);
                re = 8'($urandom) & 8'($urandom);
                checkOutput("burst in_ready", 32'(bus.in_ready), 32'd1);
                applyStimulus(1'b1, rs, rc, re);
                expResQ.push_back(modelResult(rs, rc, re));
                expEbQ.push_back(4'($countones(re)));
                if (re != 8'h00) cntModel++;
            end else begin
                applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
            end
            @(negedge clk);
        end
        checkOutput("burst count",   32'(got),         32'd16);
        checkOutput("burst err_cnt", 32'(bus.err_cnt), 32'(cntModel));

        // Stall with both stages full, then drain in order.
        bus.out_ready = 1'b0;
        xRes = modelResult(8'h3C, 8'h11, 8'h02);
        xEb  = 4'd1;
        yRes = modelResult(8'hC3, 8'hE0, 8'h00);
        applyStimulus(1'b1, 8'h3C, 8'h11, 8'h02);
        cntModel++;
        @(negedge clk);
        checkOutput("stall second in_ready", 32'(bus.in_ready), 32'd1);
        applyStimulus(1'b1, 8'hC3, 8'hE0, 8'h00);
        @(negedge clk);
        applyStimulus(1'b1, 8'h01, 8'h01, 8'h01);
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall in_ready",  32'(bus.in_ready),  32'd0);
            checkOutput("stall out_valid", 32'(bus.out_valid), 32'd1);
            checkOutput("stall result",    32'(bus.result),    32'(xRes));
            checkOutput("stall err_bits",  32'(bus.err_bits),  32'(xEb));
            @(negedge clk);
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        bus.out_ready = 1'b1;
        checkOutput("drain first",  32'(bus.result), 32'(xRes));
        @(negedge clk);
        checkOutput("drain second valid", 32'(bus.out_valid), 32'd1);
        checkOutput("drain second",       32'(bus.result),    32'(yRes));
        @(negedge clk);
        checkOutput("drain empty",   32'(bus.out_valid), 32'd0);
        checkOutput("stall err_cnt", 32'(bus.err_cnt),   32'(cntModel));

        // Saturation of the 4-bit counter from a fresh reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'h00, 8'h00, 8'h80);
            @(negedge clk);
            checkOutput("sat err_cnt", 32'(satBus.err_cnt), (i + 1 < 15) ? 32'(i + 1) : 32'd15);
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        checkOutput("wide err_cnt", 32'(bus.err_cnt), 32'd20);
        repeat (3) @(negedge clk);

        // Reset while both stages hold beats.
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 8'h11, 8'h22, 8'h04);
        @(negedge clk);
        applyStimulus(1'b1, 8'h33, 8'h44, 8'h08);
        @(negedge clk);
        applyStimulus(1'b0, 8'h00, 8'h00, 8'h00);
        checkOutput("full out_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("full in_ready",  32'(bus.in_ready),  32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst err_cnt",   32'(bus.err_cnt),   32'd0);
        checkOutput("midrst in_ready",  32'(bus.in_ready),  32'd1);
        checkOutput("midrst result",    32'(bus.result),    32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
